// File: rtl/branch_redirect.sv
// Execute-stage branch resolver: decodes and evaluates control instructions and
// drives a registered PC redirect and flush towards fetch over a valid/ready handshake.
module branch_redirect #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [XLEN-1:0]  imm,
  input  logic             kill,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic [2:0]       branch_type,
  output logic             illegal_br,
  output logic             misalign_err,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t            r_state;
  logic              r_redirect_valid;
  logic [XLEN-1:0]   r_redirect_pc;
  logic              r_flush;
  logic [2:0]        r_branch_type;
  logic              r_illegal_br;
  logic              r_misalign_err;
  logic [CNT_W-1:0]  r_branch_count;
  logic [CNT_W-1:0]  r_taken_count;

  logic              w_accept;
  logic              w_eq;
  logic              w_lt_s;
  logic              w_lt_u;
  logic              w_cond;
  logic              w_bad_f3;
  logic [2:0]        w_f3_type;
  logic [2:0]        w_type;
  logic              w_illegal;
  logic              w_taken;
  logic [XLEN-1:0]   w_target;
  logic              w_misalign;
  logic              w_issue;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign w_accept = ex_valid & (r_state == IDLE) & (is_branch | is_jal | is_jalr);
  assign w_eq     = (rs1_data == rs2_data);
  assign w_lt_s   = ($signed(rs1_data) < $signed(rs2_data));
  assign w_lt_u   = (rs1_data < rs2_data);

  // funct3 decode into branch type and condition outcome
  always_comb begin
    w_f3_type = 3'd0;
    w_cond    = 1'b0;
    w_bad_f3  = 1'b0;
    case (funct3)
      3'b000:  begin w_f3_type = 3'd1; w_cond = w_eq;    end
      3'b001:  begin w_f3_type = 3'd2; w_cond = !w_eq;   end
      3'b100:  begin w_f3_type = 3'd3; w_cond = w_lt_s;  end
      3'b101:  begin w_f3_type = 3'd4; w_cond = !w_lt_s; end
      3'b110:  begin w_f3_type = 3'd5; w_cond = w_lt_u;  end
      3'b111:  begin w_f3_type = 3'd6; w_cond = !w_lt_u; end
      default: begin w_f3_type = 3'd0; w_cond = 1'b0; w_bad_f3 = 1'b1; end
    endcase
  end

  // jalr > jal > branch priority selects type, outcome and target
  always_comb begin
    w_type    = 3'd0;
    w_illegal = 1'b0;
    w_taken   = 1'b0;
    w_target  = pc + imm;
    if (is_jalr) begin
      w_taken  = 1'b1;
      w_target = (rs1_data + imm) & ~XLEN'(1);
    end else if (is_jal) begin
      w_taken  = 1'b1;
    end else begin
      w_type    = w_f3_type;
      w_illegal = w_bad_f3;
      w_taken   = w_cond;
    end
  end

  assign w_misalign = w_taken & w_target[1];
  assign w_issue    = w_taken & !w_target[1];

  // Resolver FSM with all outputs registered; kill overrides everything but reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state          <= IDLE;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_flush          <= 1'b0;
      r_branch_type    <= 3'd0;
      r_illegal_br     <= 1'b0;
      r_misalign_err   <= 1'b0;
      r_branch_count   <= '0;
      r_taken_count    <= '0;
    end else begin
      r_flush        <= 1'b0;
      r_illegal_br   <= 1'b0;
      r_misalign_err <= 1'b0;
      if (kill) begin
        r_state          <= IDLE;
        r_redirect_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_branch_type  <= w_type;
              r_branch_count <= sat_inc(r_branch_count);
              r_illegal_br   <= w_illegal;
              r_misalign_err <= w_misalign;
              if (w_taken) begin
                r_redirect_pc <= w_target;
              end
              if (w_issue) begin
                r_state          <= HOLD;
                r_redirect_valid <= 1'b1;
                r_flush          <= 1'b1;
                r_taken_count    <= sat_inc(r_taken_count);
              end
            end
          end
          HOLD: begin
            if (redirect_ready) begin
              r_state          <= IDLE;
              r_redirect_valid <= 1'b0;
            end
          end
          default: begin
            r_state          <= IDLE;
            r_redirect_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ex_ready       = (r_state == IDLE);
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign flush          = r_flush;
  assign branch_type    = r_branch_type;
  assign illegal_br     = r_illegal_br;
  assign misalign_err   = r_misalign_err;
  assign branch_count   = r_branch_count;
  assign taken_count    = r_taken_count;

endmodule

// File: tb/tb_branch_redirect.sv
// Self-checking bench for branch_redirect: directed vector table, hand-written
// handshake/kill/reset sequences, then random traffic against a behavioural model.
module tb_branch_redirect;

  logic        clk = 1'b0;
  logic        nrst, ex_valid, is_branch, is_jal, is_jalr, kill, redirect_ready;
  logic [2:0]  funct3;
  logic [31:0] pc, rs1_data, rs2_data, imm;
  logic        ex_ready, redirect_valid, flush, illegal_br, misalign_err;
  logic [31:0] redirect_pc;
  logic [2:0]  branch_type;
  logic [15:0] branch_count, taken_count;

  int errors = 0;
  int checks = 0;

  // model state
  bit          m_hold, m_valid, m_flush, m_ill, m_mis;
  logic [31:0] m_pc;
  int          m_type, m_bc, m_tc;

  always #5 clk = ~clk;

  branch_redirect #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .nrst(nrst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
    .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .kill(kill),
    .redirect_ready(redirect_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .branch_type(branch_type),
    .illegal_br(illegal_br), .misalign_err(misalign_err),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: what the outputs must be after the coming edge
  task automatic model_step();
    int kind;
    bit taken;
    int typ;
    logic [31:0] tgt;
    if (!nrst) begin
      m_hold = 0; m_valid = 0; m_flush = 0; m_ill = 0; m_mis = 0;
      m_pc = 32'h0; m_type = 0; m_bc = 0; m_tc = 0;
      return;
    end
    m_flush = 0; m_ill = 0; m_mis = 0;
    if (kill) begin
      m_hold = 0; m_valid = 0;
    end else if (m_hold) begin
      if (redirect_ready) begin m_hold = 0; m_valid = 0; end
    end else if (ex_valid && (is_branch || is_jal || is_jalr)) begin
      kind = is_jalr ? 2 : (is_jal ? 1 : 0);
      typ = 0;
      tgt = pc + imm;
      if (kind == 2) begin
        taken = 1; tgt = (rs1_data + imm) & 32'hFFFF_FFFE;
      end else if (kind == 1) begin
        taken = 1;
      end else begin
        case (funct3)
          3'd0: begin typ = 1; taken = (rs1_data == rs2_data); end
          3'd1: begin typ = 2; taken = (rs1_data != rs2_data); end
          3'd4: begin typ = 3; taken = (int'(rs1_data) < int'(rs2_data)); end
          3'd5: begin typ = 4; taken = (int'(rs1_data) >= int'(rs2_data)); end
          3'd6: begin typ = 5; taken = (longint'(rs1_data) < longint'(rs2_data)); end
          3'd7: begin typ = 6; taken = (longint'(rs1_data) >= longint'(rs2_data)); end
          default: begin typ = 0; taken = 0; m_ill = 1; end
        endcase
      end
      m_type = typ;
      m_bc = (m_bc < 65535) ? m_bc + 1 : 65535;
      if (taken) begin
        m_pc = tgt;
        if (tgt[1]) m_mis = 1;
        else begin
          m_hold = 1; m_valid = 1; m_flush = 1;
          m_tc = (m_tc < 65535) ? m_tc + 1 : 65535;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("ex_ready", 32'(ex_ready), 32'(!m_hold));
    check("redirect_valid", 32'(redirect_valid), 32'(m_valid));
    check("redirect_pc", redirect_pc, m_pc);
    check("flush", 32'(flush), 32'(m_flush));
    check("branch_type", 32'(branch_type), 32'(m_type));
    check("illegal_br", 32'(illegal_br), 32'(m_ill));
    check("misalign_err", 32'(misalign_err), 32'(m_mis));
    check("branch_count", 32'(branch_count), 32'(m_bc));
    check("taken_count", 32'(taken_count), 32'(m_tc));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic set_instr(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                           input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] im);
    is_branch = br; is_jal = jal; is_jalr = jalr; funct3 = f3;
    pc = p; rs1_data = a; rs2_data = b; imm = im;
  endtask

  typedef struct {
    logic        br, jal, jalr;
    logic [2:0]  f3;
    logic [31:0] p, a, b, im;
    logic        e_valid, e_taken;
    logic [31:0] e_pc;
    logic [2:0]  e_type;
    logic        e_ill, e_mis;
  } vec_t;

  vec_t vt[13];

  initial begin
    int bc0, tc0;
    vt[0]  = '{1'b1,1'b0,1'b0,3'd0,32'h100,32'd5,32'd5,32'h20, 1'b1,1'b1,32'h120,3'd1,1'b0,1'b0};
    vt[1]  = '{1'b1,1'b0,1'b0,3'd5,32'h100,32'hFFFF_FFFF,32'd1,32'h20, 1'b0,1'b0,32'h0,3'd4,1'b0,1'b0};
    vt[2]  = '{1'b1,1'b0,1'b0,3'd7,32'h200,32'hFFFF_FFFF,32'd1,32'h40, 1'b1,1'b1,32'h240,3'd6,1'b0,1'b0};
    vt[3]  = '{1'b1,1'b0,1'b0,3'd5,32'h300,32'd7,32'd7,32'h8, 1'b1,1'b1,32'h308,3'd4,1'b0,1'b0};
    vt[4]  = '{1'b1,1'b0,1'b0,3'd1,32'h300,32'd3,32'd3,32'h8, 1'b0,1'b0,32'h0,3'd2,1'b0,1'b0};
    vt[5]  = '{1'b1,1'b0,1'b0,3'd4,32'h400,32'hFFFF_FFFB,32'd2,32'hFFFF_FFF0, 1'b1,1'b1,32'h3F0,3'd3,1'b0,1'b0};
    vt[6]  = '{1'b1,1'b0,1'b0,3'd6,32'h10,32'd2,32'hFFFF_FFFB,32'h10, 1'b1,1'b1,32'h20,3'd5,1'b0,1'b0};
    vt[7]  = '{1'b0,1'b0,1'b1,3'd0,32'h0,32'h203,32'd0,32'h0, 1'b0,1'b1,32'h202,3'd0,1'b0,1'b1};
    vt[8]  = '{1'b0,1'b0,1'b1,3'd0,32'h0,32'h205,32'd0,32'h0, 1'b1,1'b1,32'h204,3'd0,1'b0,1'b0};
    vt[9]  = '{1'b0,1'b1,1'b0,3'd0,32'hFFFF_FFF0,32'd0,32'd0,32'h20, 1'b1,1'b1,32'h10,3'd0,1'b0,1'b0};
    vt[10] = '{1'b1,1'b0,1'b0,3'd2,32'h100,32'd1,32'd1,32'h20, 1'b0,1'b0,32'h0,3'd0,1'b1,1'b0};
    vt[11] = '{1'b1,1'b0,1'b0,3'd0,32'h100,32'd1,32'd1,32'h6, 1'b0,1'b1,32'h106,3'd1,1'b0,1'b1};
    vt[12] = '{1'b1,1'b1,1'b0,3'd1,32'h40,32'd9,32'd9,32'h4, 1'b1,1'b1,32'h44,3'd0,1'b0,1'b0};

    nrst = 1'b0; ex_valid = 1'b0; kill = 1'b0; redirect_ready = 1'b0;
    set_instr(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    cycle();
    cycle();
    check("reset_valid", 32'(redirect_valid), 32'h0);
    check("reset_ready", 32'(ex_ready), 32'h1);
    check("reset_count", 32'(branch_count), 32'h0);
    nrst = 1'b1;

    // directed vectors, each started from IDLE
    for (int i = 0; i < 13; i++) begin
      set_instr(vt[i].br, vt[i].jal, vt[i].jalr, vt[i].f3, vt[i].p, vt[i].a, vt[i].b, vt[i].im);
      ex_valid = 1'b1; redirect_ready = 1'b0;
      cycle();
      check($sformatf("vec%0d_valid", i), 32'(redirect_valid), 32'(vt[i].e_valid));
      check($sformatf("vec%0d_flush", i), 32'(flush), 32'(vt[i].e_valid));
      check($sformatf("vec%0d_type", i), 32'(branch_type), 32'(vt[i].e_type));
      check($sformatf("vec%0d_ill", i), 32'(illegal_br), 32'(vt[i].e_ill));
      check($sformatf("vec%0d_mis", i), 32'(misalign_err), 32'(vt[i].e_mis));
      if (vt[i].e_taken) check($sformatf("vec%0d_pc", i), redirect_pc, vt[i].e_pc);
      ex_valid = 1'b0; redirect_ready = 1'b1;
      cycle();
      check($sformatf("vec%0d_flush_pulse", i), 32'(flush), 32'h0);
      redirect_ready = 1'b0;
    end

    // back-pressure: held redirect, waiting instruction accepted after release
    set_instr(1'b1, 1'b0, 1'b0, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20);
    ex_valid = 1'b1;
    cycle();
    bc0 = m_bc;
    set_instr(1'b1, 1'b0, 1'b0, 3'd1, 32'h500, 32'd1, 32'd2, 32'h10);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("hold_ex_ready", 32'(ex_ready), 32'h0);
      check("hold_pc_stable", redirect_pc, 32'h120);
      check("hold_valid", 32'(redirect_valid), 32'h1);
    end
    redirect_ready = 1'b1;
    cycle();
    check("release_valid", 32'(redirect_valid), 32'h0);
    check("release_count", 32'(branch_count), 32'(bc0));
    redirect_ready = 1'b0;
    cycle();
    check("waiting_accept_valid", 32'(redirect_valid), 32'h1);
    check("waiting_accept_pc", redirect_pc, 32'h510);
    check("waiting_accept_count", 32'(branch_count), 32'(bc0 + 1));

    // kill in HOLD overrides redirect_ready and leaves counters alone
    ex_valid = 1'b0; kill = 1'b1; redirect_ready = 1'b1;
    bc0 = m_bc; tc0 = m_tc;
    cycle();
    check("kill_hold_valid", 32'(redirect_valid), 32'h0);
    check("kill_hold_ready", 32'(ex_ready), 32'h1);
    check("kill_hold_bc", 32'(branch_count), 32'(bc0));
    check("kill_hold_tc", 32'(taken_count), 32'(tc0));

    // kill discards a same-cycle accept
    set_instr(1'b0, 1'b1, 1'b0, 3'd0, 32'h800, 32'd0, 32'd0, 32'h8);
    ex_valid = 1'b1; redirect_ready = 1'b0;
    cycle();
    check("kill_accept_valid", 32'(redirect_valid), 32'h0);
    check("kill_accept_bc", 32'(branch_count), 32'(bc0));
    kill = 1'b0;

    // reset while HOLD drops the pending redirect
    cycle();
    check("pre_reset_valid", 32'(redirect_valid), 32'h1);
    ex_valid = 1'b0; nrst = 1'b0;
    cycle();
    check("midhold_reset_valid", 32'(redirect_valid), 32'h0);
    check("midhold_reset_pc", redirect_pc, 32'h0);
    check("midhold_reset_bc", 32'(branch_count), 32'h0);
    check("midhold_reset_tc", 32'(taken_count), 32'h0);
    check("midhold_reset_type", 32'(branch_type), 32'h0);
    nrst = 1'b1;

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      nrst = ($urandom_range(0, 99) != 0);
      kill = ($urandom_range(0, 15) == 0);
      redirect_ready = $urandom_range(0, 1);
      ex_valid = $urandom_range(0, 1);
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = {29'h0, 3'(a)};
      set_instr($urandom_range(0, 1), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                3'($urandom), $urandom & 32'hFFFF_FFFC, a,
                ($urandom_range(0, 2) == 0) ? a : (($urandom_range(0, 1) == 0) ? {29'h0, 3'($urandom)} : $urandom),
                $urandom_range(0, 1) ? 32'($urandom_range(0, 64)) : -32'($urandom_range(0, 64)));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
